// File: rtl/waveform_buffer.sv
// Heart-signal waveform store: decimates incoming samples into a ring buffer and
// serves per-column lookups against a frame-start snapshot so the display never tears.
module waveform_buffer #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned DECIM_LOG2  = 2,
  parameter logic [7:0]  BLANK_LEVEL = 8'd128
) (
  input  logic                  clk_65mhz,
  input  logic                  reset_n,
  input  logic                  sample_valid,
  input  logic [7:0]            sample_in,
  input  logic [2:0]            system_status,
  input  logic                  frame_start,
  input  logic [DEPTH_LOG2:0]   signal_pix,
  output logic [7:0]            signal_in,
  output logic                  buffer_full,
  output logic [DEPTH_LOG2:0]   fill_count
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned ACC_W  = 8 + DECIM_LOG2;
  localparam int unsigned FILL_W = DEPTH_LOG2 + 1;

  localparam logic [2:0] ST_RUNNING = 3'd1;
  localparam logic [2:0] ST_BOOT    = 3'd3;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] base;
  logic [DEPTH_LOG2:0]   disp_fill;
  logic [ACC_W-1:0]      acc;
  logic [DECIM_LOG2-1:0] dcnt;
  logic [2:0]            prev_status;
  logic [7:0]            rd_data;
  logic                  blank_q;

  logic                  running;
  logic                  group_done;
  logic                  boot_entry;
  logic [ACC_W-1:0]      acc_sum;
  logic [7:0]            wr_data;
  logic [DEPTH_LOG2:0]   fill_next;
  logic [DEPTH_LOG2-1:0] age;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  rd_blank;

  // Write-side decode and fill bookkeeping
  always_comb begin
    running    = (system_status == ST_RUNNING);
    acc_sum    = acc + ACC_W'(sample_in);
    wr_data    = 8'(acc_sum >> DECIM_LOG2);
    group_done = running && sample_valid && (dcnt == '1);
    boot_entry = (system_status == ST_BOOT) && (prev_status != ST_BOOT);
    fill_next  = fill_count;
    if (boot_entry) begin
      fill_next = '0;
    end else if (group_done && (fill_count != FILL_W'(DEPTH))) begin
      fill_next = fill_count + 1'b1;
    end
  end

  // Read mapping: rightmost column is newest; age is measured back from it
  always_comb begin
    age      = ~signal_pix[DEPTH_LOG2-1:0];
    rd_addr  = base + signal_pix[DEPTH_LOG2-1:0];
    rd_blank = signal_pix[DEPTH_LOG2] || ({1'b0, age} >= disp_fill);
  end

  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      fill_count  <= '0;
      buffer_full <= 1'b0;
      acc         <= '0;
      dcnt        <= '0;
      base        <= '0;
      disp_fill   <= '0;
      prev_status <= '0;
      blank_q     <= 1'b1;
    end else begin
      if (!running) begin
        acc  <= '0;
        dcnt <= '0;
      end else if (sample_valid) begin
        if (dcnt == '1) begin
          acc    <= '0;
          dcnt   <= '0;
          wr_ptr <= wr_ptr + 1'b1;
        end else begin
          acc  <= acc_sum;
          dcnt <= dcnt + 1'b1;
        end
      end
      fill_count  <= fill_next;
      buffer_full <= (fill_next == FILL_W'(DEPTH));
      // Pre-write values are latched, so a same-cycle write shows up next frame
      if (frame_start) begin
        base      <= wr_ptr;
        disp_fill <= fill_count;
      end
      prev_status <= system_status;
      blank_q     <= rd_blank;
    end
  end

  // Simple dual-port RAM, synchronous read returning old data on collision
  always_ff @(posedge clk_65mhz) begin
    if (group_done) begin
      mem[wr_ptr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  assign signal_in = blank_q ? BLANK_LEVEL : rd_data;

endmodule

// File: tb/tb_waveform_buffer.sv
// Scoreboard bench for waveform_buffer: a reference model predicts each column
// lookup, expectations are queued when signal_pix is driven and checked one cycle later.
module tb_waveform_buffer;

  logic        clk_65mhz = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [7:0]  sample_in;
  logic [2:0]  system_status;
  logic        frame_start;
  logic [10:0] signal_pix;
  logic [7:0]  signal_in;
  logic        buffer_full;
  logic [10:0] fill_count;

  always #5 clk_65mhz = ~clk_65mhz;

  waveform_buffer dut (
    .clk_65mhz    (clk_65mhz),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .system_status(system_status),
    .frame_start  (frame_start),
    .signal_pix   (signal_pix),
    .signal_in    (signal_in),
    .buffer_full  (buffer_full),
    .fill_count   (fill_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [7:0] m_mem [1024];
  int m_wr, m_fill, m_acc, m_dcnt, m_base, m_disp;
  logic [7:0] exp_q [$];

  function automatic logic [7:0] exp_col(input int c);
    if (c >= 1024) return 8'd128;
    if ((1023 - c) >= m_disp) return 8'd128;
    return m_mem[(m_base + c) % 1024];
  endfunction

  task automatic model_reset();
    m_wr = 0; m_fill = 0; m_acc = 0; m_dcnt = 0; m_base = 0; m_disp = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk_65mhz);
    reset_n = 1'b0; sample_valid = 1'b0; sample_in = '0;
    system_status = 3'd0; frame_start = 1'b0; signal_pix = '0;
    repeat (2) @(negedge clk_65mhz);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic set_status(input logic [2:0] s);
    if (s == 3'd3 && system_status != 3'd3) m_fill = 0;
    if (s != 3'd1) begin m_acc = 0; m_dcnt = 0; end
    system_status = s;
    @(negedge clk_65mhz);
  endtask

  task automatic send_sample(input logic [7:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    if (system_status == 3'd1) begin
      if (m_dcnt == 3) begin
        m_mem[m_wr] = 8'((m_acc + int'(v)) / 4);
        m_wr = (m_wr + 1) % 1024;
        if (m_fill < 1024) m_fill++;
        m_acc = 0; m_dcnt = 0;
      end else begin
        m_acc += int'(v); m_dcnt++;
      end
    end
    @(negedge clk_65mhz);
    sample_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    m_base = m_wr; m_disp = m_fill;
    @(negedge clk_65mhz);
    frame_start = 1'b0;
  endtask

  // Queue the expected column, drive it, and check the registered result a cycle later
  task automatic sb_read(input int pix, input logic [7:0] exp);
    logic [7:0] want;
    exp_q.push_back(exp);
    signal_pix = 11'(pix);
    @(negedge clk_65mhz);
    want = exp_q.pop_front();
    n_total++;
    if (signal_in !== want)
      $display("FAIL read pix=%0d: got %0d, expected %0d", pix, signal_in, want);
    else
      n_pass++;
  endtask

  task automatic sweep(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) sb_read(c, exp_col(c));
  endtask

  task automatic send_test2_stimulus();
    for (int i = 1; i <= 8; i++) send_sample(8'(i * 10));
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (signal_in !== 8'd128 || fill_count !== 11'd0 || buffer_full !== 1'b0)
      $display("FAIL reset: signal_in=%0d fill=%0d full=%0b, expected 128/0/0",
               signal_in, fill_count, buffer_full);
    else n_pass++;
  endtask

  task automatic test_empty_read();
    pulse_frame();
    for (int c = 0; c <= 1100; c++) sb_read(c, 8'd128);
    n_total++;
    if (fill_count !== 11'd0 || buffer_full !== 1'b0)
      $display("FAIL empty_fill: fill=%0d full=%0b, expected 0/0", fill_count, buffer_full);
    else n_pass++;
  endtask

  task automatic test_decimation();
    do_reset();
    set_status(3'd1);
    send_test2_stimulus();
    pulse_frame();
    n_total++;
    if (fill_count !== 11'd2 || buffer_full !== 1'b0)
      $display("FAIL decim_fill: fill=%0d full=%0b, expected 2/0", fill_count, buffer_full);
    else n_pass++;
    sb_read(1023, 8'd65);
    sb_read(1022, 8'd25);
    sb_read(1021, 8'd128);
    sweep(0, 1023);
  endtask

  task automatic test_snapshot_boot();
    for (int i = 0; i < 4; i++) send_sample(8'd90);
    sb_read(1023, 8'd65);
    n_total++;
    if (fill_count !== 11'd3)
      $display("FAIL snap_fill: fill=%0d, expected 3", fill_count);
    else n_pass++;
    pulse_frame();
    sb_read(1023, 8'd90);
    sb_read(1022, 8'd65);
    sb_read(1021, 8'd25);
    sb_read(1020, 8'd128);
    set_status(3'd3);
    pulse_frame();
    n_total++;
    if (fill_count !== 11'd0 || buffer_full !== 1'b0)
      $display("FAIL boot_fill: fill=%0d full=%0b, expected 0/0", fill_count, buffer_full);
    else n_pass++;
    for (int c = 0; c <= 1023; c++) sb_read(c, 8'd128);
  endtask

  task automatic test_partial_discard();
    do_reset();
    set_status(3'd1);
    for (int i = 0; i < 3; i++) send_sample(8'd200);
    set_status(3'd0);
    repeat (4) @(negedge clk_65mhz);
    set_status(3'd1);
    for (int i = 0; i < 4; i++) send_sample(8'd100);
    pulse_frame();
    n_total++;
    if (fill_count !== 11'd1)
      $display("FAIL partial_fill: fill=%0d, expected 1", fill_count);
    else n_pass++;
    sb_read(1023, 8'd100);
    sb_read(1022, 8'd128);
  endtask

  task automatic test_wrap();
    do_reset();
    set_status(3'd1);
    for (int k = 0; k < 1028; k++)
      for (int i = 0; i < 4; i++) send_sample(8'(k));
    pulse_frame();
    n_total++;
    if (fill_count !== 11'd1024 || buffer_full !== 1'b1)
      $display("FAIL wrap_fill: fill=%0d full=%0b, expected 1024/1", fill_count, buffer_full);
    else n_pass++;
    sb_read(1023, 8'd3);
    sb_read(0, 8'd4);
    sb_read(1024, 8'd128);
    sb_read(2047, 8'd128);
    sweep(0, 1023);
  endtask

  task automatic test_async_reset();
    do_reset();
    set_status(3'd1);
    send_test2_stimulus();
    pulse_frame();
    sb_read(1023, 8'd65);
    @(posedge clk_65mhz);
    #3;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (signal_in !== 8'd128 || fill_count !== 11'd0 || buffer_full !== 1'b0)
      $display("FAIL async_reset: signal_in=%0d fill=%0d full=%0b, expected 128/0/0",
               signal_in, fill_count, buffer_full);
    else n_pass++;
    system_status = 3'd0; sample_valid = 1'b0; frame_start = 1'b0;
    repeat (2) @(negedge clk_65mhz);
    reset_n = 1'b1;
    model_reset();
    set_status(3'd1);
    send_test2_stimulus();
    pulse_frame();
    n_total++;
    if (fill_count !== 11'd2)
      $display("FAIL post_reset_fill: fill=%0d, expected 2", fill_count);
    else n_pass++;
    sb_read(1023, 8'd65);
    sb_read(1022, 8'd25);
    sb_read(1021, 8'd128);
  endtask

  initial begin
    reset_n = 1'b1; sample_valid = 1'b0; sample_in = '0;
    system_status = 3'd0; frame_start = 1'b0; signal_pix = '0;
    model_reset();
    test_reset();
    test_empty_read();
    test_decimation();
    test_snapshot_boot();
    test_partial_discard();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/waveform_buffer.md
Name: waveform_buffer

Overview:
- Upstream stage of the top-level display. Captures incoming 8-bit heart-signal samples, decimates them, and stores them in a 1024-entry ring buffer.
- Serves the display's per-column sample lookup: it receives the column index (signal_pix) and returns the sample to draw (signal_in).
- Display contents are snapshotted at frame start, so the drawn waveform never tears mid-frame.

Parameters:
- DEPTH_LOG2, 10: buffer depth is 2^DEPTH_LOG2 columns (1024, equal to the screen width).
- DECIM_LOG2, 2: 2^DECIM_LOG2 input samples are averaged into each stored column.
- BLANK_LEVEL, 8'd128: value returned for empty or out-of-range columns (midline).

Ports:
- clk_65mhz  input  1  sole clock, the pixel clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- sample_valid  input  1  single-cycle strobe qualifying sample_in.
- sample_in  input  8  unsigned sample.
- system_status  input  3  0 paused, 1 running, 2 error, 3 boot.
- frame_start  input  1  single-cycle pulse once per frame, before the first visible line.
- signal_pix  input  11  column being drawn (hcount).
- signal_in  output  8  sample for the previous cycle's signal_pix.
- buffer_full  output  1  fill_count == 1024.
- fill_count  output  11  number of valid stored columns, saturating at 1024.

Behaviour:
- Reset (asynchronous, active-low) clears:
  - wr_ptr=0, fill_count=0, acc=0, dcnt=0, base=0, disp_fill=0, prev_status=0.
  - signal_in=BLANK_LEVEL, buffer_full=0.
  - Memory contents are not cleared; fill_count masks them.
- Accumulate. Applies only when system_status==1 and sample_valid:
  - acc (8+DECIM_LOG2 bits) += sample_in; dcnt increments.
  - When dcnt == 2^DECIM_LOG2-1 on a valid sample:
    - mem[wr_ptr] <= (acc+sample_in) >> DECIM_LOG2, i.e. truncating floor average.
    - wr_ptr increments, wrapping from 1023 to 0.
    - fill_count increments, saturating at 1024.
    - acc and dcnt clear.
- Non-running. When system_status != 1:
  - sample_valid is ignored.
  - acc and dcnt clear every cycle, so a partial group is discarded.
  - wr_ptr and memory are held.
- Boot entry. On the cycle where system_status==3 and prev_status != 3, fill_count clears to 0. wr_ptr is held.
- Snapshot. On frame_start, base <= wr_ptr and disp_fill <= fill_count.
  - If a write occurs in the same cycle, the pre-write values are latched; the new column appears next frame.
  - Writes between frame_start pulses never alter the displayed frame's mapping.
- Read mapping. For column c = signal_pix:
  - age = 1023 - c.
  - addr = (base + c) mod 1024; column 1023 is the newest sample, column 0 the oldest.
  - If signal_pix >= 1024, or age >= disp_fill, the output is BLANK_LEVEL; otherwise it is mem[addr].
  - The result is registered: 1-cycle latency from signal_pix to signal_in.
  - Memory is inferred as simple dual-port BRAM with a synchronous read.
- Write/read same address in the same cycle: the read returns the old data. This cannot be observed on screen, because the snapshot excludes columns written after frame_start.
- Unused status codes 4-7 behave as non-running.
- Arithmetic: the accumulator cannot overflow (max 255·2^DECIM_LOG2 fits). Pointer addition is modulo 2^DEPTH_LOG2.

Test Plan:
1. Empty read: reset, frame_start, sweep signal_pix 0..1100 -> signal_in=128 everywhere, one cycle after each pix; fill_count=0, buffer_full=0.
2. Decimation and order: status=1, samples 10,20,30,40,50,60,70,80, then frame_start.
   - Required: fill_count=2.
   - pix 1023 -> 65; pix 1022 -> 25; pix 1021 -> 128.
3. Partial-group discard: status=1, samples 200,200,200; status=0 for 5 cycles; status=1, samples 100×4; frame_start -> pix 1023 -> 100, fill_count=1.
4. Wrap and saturation: write 1028 groups with column k holding k[7:0], then frame_start.
   - Required: fill_count=1024, buffer_full=1, wr_ptr=4.
   - pix 1023 -> 1027[7:0]=3; pix 0 -> 4.
5. Snapshot and boot:
   - After test 2, complete one more group (value 90) without a new frame_start -> pix 1023 still 65.
   - After frame_start -> pix 1023 = 90.
   - Then status 1→3, frame_start -> all columns 128, fill_count=0.
6. Async reset mid-frame: assert reset_n=0 between clock edges -> signal_in=128 and fill_count=0 immediately. Deassert reset, then apply test 2 stimulus -> the same results as test 2.
